// File: rtl/temp_ctrl_pkg.sv
// temp_ctrl_pkg: FSM state encoding and lane geometry defaults for temp_acc_ctrl
package temp_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_READ, S_ADD, S_WRITE, S_DONE} state_t;
  localparam int LANE_W_DEF = 16;
  localparam int LANES_DEF  = 4;
endpackage

// File: rtl/temp_acc_ctrl_if.sv
// temp_acc_ctrl_if: upstream stream, result stream and temp BRAM port of temp_acc_ctrl
interface temp_acc_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
);
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  rd_temp_en_o;
  logic                  wr_temp_en_o;
  logic [ADDR_WIDTH-1:0] temp_addr_o;
  logic [DATA_WIDTH-1:0] temp_wdata_o;
  logic [DATA_WIDTH-1:0] temp_rdata_i;
  modport slave (
    input  in_valid_i, in_data_i, temp_rdata_i,
    output in_ready_o, out_valid_o, out_data_o, rd_temp_en_o, wr_temp_en_o, temp_addr_o, temp_wdata_o
  );
  modport master (
    output in_valid_i, in_data_i, temp_rdata_i,
    input  in_ready_o, out_valid_o, out_data_o, rd_temp_en_o, wr_temp_en_o, temp_addr_o, temp_wdata_o
  );
endinterface

// File: rtl/temp_lane_add.sv
// temp_lane_add: one signed lane add; saturating when TEMP_ACC_SAT_EN is defined, wrapping otherwise
module temp_lane_add #(
  parameter int LANE_W = 16
) (
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [LANE_W-1:0] o_y
);
`ifdef TEMP_ACC_SAT_EN
  localparam logic [LANE_W-1:0] MAX_V = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] MIN_V = {1'b1, {(LANE_W-1){1'b0}}};
  logic [LANE_W:0] w_full;
  assign w_full = {i_a[LANE_W-1], i_a} + {i_b[LANE_W-1], i_b};
  // overflow shows as the extended sign disagreeing with the lane sign
  assign o_y = (w_full[LANE_W] != w_full[LANE_W-1]) ? (w_full[LANE_W] ? MIN_V : MAX_V) : w_full[LANE_W-1:0];
`else
  assign o_y = i_a + i_b;
`endif
endmodule

// File: rtl/temp_acc_ctrl.sv
// temp_acc_ctrl: multi-pass lane-wise accumulator over a temp BRAM (optional saturation: TEMP_ACC_SAT_EN)
module temp_acc_ctrl
  import temp_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3,
  parameter int LANE_W     = LANE_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] num_pass_i,
  output logic       busy_o,
  output logic       done_o,
  temp_acc_ctrl_if.slave bus
);
  localparam int LANES = DATA_WIDTH / LANE_W;
  state_t                r_state, w_next;
  logic [3:0]            r_num_pass, r_pass;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_in, r_sum, w_sum, w_wdata;
  logic                  w_last_pass, w_last_word;
  assign w_last_pass = r_pass == r_num_pass - 4'd1;
  assign w_last_word = &r_addr;
  assign w_wdata     = (r_pass == 4'd0) ? r_in : r_sum;
  genvar i;
  for (i = 0; i < LANES; i++) begin : g_lane
    temp_lane_add #(.LANE_W(LANE_W)) u_add (
      .i_a(r_in[i*LANE_W +: LANE_W]),
      .i_b(bus.temp_rdata_i[i*LANE_W +: LANE_W]),
      .o_y(w_sum[i*LANE_W +: LANE_W])
    );
  end
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  // next-state: pass 0 skips the read-modify part of the word loop
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start_i ? S_ACCEPT : S_IDLE;
      S_ACCEPT: w_next = bus.in_valid_i ? ((r_pass == 4'd0) ? S_WRITE : S_READ) : S_ACCEPT;
      S_READ:   w_next = S_ADD;
      S_ADD:    w_next = S_WRITE;
      S_WRITE:  w_next = (w_last_pass && w_last_word) ? S_DONE : S_ACCEPT;
      default:  w_next = S_IDLE;
    endcase
  end
  // state-decoded outputs; data buses are forced to zero outside their valid cycles
  always_comb begin
    busy_o           = r_state != S_IDLE;
    done_o           = r_state == S_DONE;
    bus.in_ready_o   = r_state == S_ACCEPT;
    bus.rd_temp_en_o = r_state == S_READ;
    bus.wr_temp_en_o = r_state == S_WRITE;
    bus.temp_addr_o  = r_addr;
    bus.temp_wdata_o = (r_state == S_WRITE) ? w_wdata : '0;
    bus.out_valid_o  = (r_state == S_WRITE) && w_last_pass;
    bus.out_data_o   = ((r_state == S_WRITE) && w_last_pass) ? w_wdata : '0;
  end
  // job counters and data registers
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_num_pass <= '0;
      r_pass     <= '0;
      r_addr     <= '0;
      r_in       <= '0;
      r_sum      <= '0;
    end else begin
      if (r_state == S_IDLE && start_i) begin
        r_num_pass <= (num_pass_i == 4'd0) ? 4'd1 : num_pass_i;
        r_pass     <= '0;
        r_addr     <= '0;
      end
      if (r_state == S_ACCEPT && bus.in_valid_i) r_in <= bus.in_data_i;
      if (r_state == S_ADD) r_sum <= w_sum;
      if (r_state == S_WRITE) begin
        r_addr <= r_addr + 1'b1;
        if (w_last_word) r_pass <= r_pass + 4'd1;
      end
    end
endmodule

// File: doc/temp_acc_ctrl.md
TEMP_ACC_CTRL -- requirements
Module: temp_acc_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, BRAM word width; must be a multiple of LANE_W.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, BRAM address width; each pass covers 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter LANE_W, default 16, signed lane width; LANES = DATA_WIDTH/LANE_W.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk_i  in  1  clock; all logic on rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 start_i  in  1  begin a job; sampled only in IDLE.
REQ-008 num_pass_i  in  4  passes per job, latched at start; 0 is treated as 1.
REQ-009 in_valid_i / in_data_i  in  1 / DATA_WIDTH  upstream vector stream.
REQ-010 in_ready_o  out  1  upstream ready.
REQ-011 out_valid_o / out_data_o  out  1 / DATA_WIDTH  final-pass results; no backpressure.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 done_o  out  1  one-cycle job-complete pulse.
REQ-014 rd_temp_en_o, wr_temp_en_o  out  1 each  BRAM read and write enables.
REQ-015 temp_addr_o  out  ADDR_WIDTH  BRAM address.
REQ-016 temp_wdata_o  out  DATA_WIDTH  BRAM write data.
REQ-017 temp_rdata_i  in  DATA_WIDTH  BRAM registered read data; valid exactly one cycle after rd_temp_en_o.

Function
REQ-018 SHALL implement FSM states IDLE, ACCEPT, READ, ADD, WRITE, DONE.
REQ-019 IDLE: on start_i, latch num_pass_i, clear the pass and address counters, and go to ACCEPT.
REQ-020 ACCEPT: in_ready_o=1; on in_valid_i, latch in_data_i; go to WRITE if pass==0, else READ.
REQ-021 READ: rd_temp_en_o=1 with temp_addr_o=addr for one cycle; go to ADD.
REQ-022 ADD: capture temp_rdata_i and register the lane-wise sum with the latched input; go to WRITE.
REQ-023 WRITE: wr_temp_en_o=1 with temp_wdata_o = latched input (pass 0) or the registered sum (pass>0).
REQ-024 In WRITE of the last pass, out_valid_o=1 and out_data_o=temp_wdata_o in the same cycle.
REQ-025 Leaving WRITE: addr increments; on wrap from max to 0, pass increments; after the last word of the last pass, go to DONE, else ACCEPT.
REQ-026 DONE: done_o=1 for one cycle; go to IDLE.
REQ-027 rd_temp_en_o and wr_temp_en_o SHALL never be high in the same cycle.
REQ-028 Arithmetic: independent signed LANE_W-bit add per lane, with no carry between lanes.
REQ-029 Throughput: 2 cycles per word in pass 0 and 4 cycles per word in later passes, with in_valid_i held high.
REQ-030 start_i while busy_o=1 SHALL be ignored.

Reset
REQ-031 rst_i SHALL force IDLE and clear counters and registers; all outputs are 0 the cycle after assertion, including mid-job.

Configuration
REQ-032 With TEMP_ACC_SAT_EN defined, lane adds SHALL saturate to [-2**(LANE_W-1), 2**(LANE_W-1)-1].
REQ-033 Without TEMP_ACC_SAT_EN, lane adds SHALL wrap modulo 2**LANE_W.

Structure
REQ-034 Package temp_ctrl_pkg SHALL hold the FSM state encoding and the LANE_W and LANES defaults.
REQ-035 One sub-module, temp_lane_add (single-lane add with optional saturation), SHALL be instantiated LANES times.

Verification
REQ-036 Bench SHALL pair the block with the BRAM model; num_pass=1 with inputs 0..7 -> out_data 0..7, 8 pulses, 16 cycles from first accept to last WRITE, then done_o.
REQ-037 num_pass=3, every lane=1 per input -> each out_data lane=3, exactly 8 out_valid pulses.
REQ-038 num_pass=2, lane 0 = 0x7FFF then 0x0001 -> 0x8000 without the macro, 0x7FFF with TEMP_ACC_SAT_EN; 0x8000 + 0xFFFF -> 0x7FFF wrapped, 0x8000 saturated.
REQ-039 in_valid_i low for 5 cycles mid-pass -> FSM holds in ACCEPT, no BRAM enables; results unchanged.
REQ-040 rst_i asserted during READ of pass 1 -> outputs 0 next cycle, FSM in IDLE, and a new job completes normally.
REQ-041 Assertion on every cycle: no cycle with rd_temp_en_o && wr_temp_en_o; start_i pulse while busy -> no effect.
